instr_encoder: RTL

Instruction encoder and loader for the single-cycle MIPS core. It accepts symbolic instructions (operation class plus register, immediate and target fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. Words use the opcode map the main control decoder recognises. Each encoded word is written sequentially into instruction memory through a registered write port. The block is the producer end of the path whose consumer is the main control decoder, and it is used to boot-load and regenerate test programs.

---
 rtl/mips_defs.sv | 42 ++++
 rtl/instr_pack.sv | 33 +++
 rtl/instr_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode map, encoder operation classes and loader FSM states.
// The main control decoder and the instruction encoder both draw their opcodes from here.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_ANDI    = 3'd2,
    CLS_LW      = 3'd3,
    CLS_SW      = 3'd4,
    CLS_BEQ     = 3'd5,
    CLS_J       = 3'd6,
    CLS_ILLEGAL = 3'd7
  } opClass_e;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FULL = 2'd1,
    S_ERR  = 2'd2
  } loadState_e;

  // Opcode for the I-type classes; other classes return OP_RTYPE and are packed separately.
  function automatic logic [5:0] iTypeOpcode(input opClass_e cls);
    case (cls)
      CLS_ADDI: return OP_ADDI;
      CLS_ANDI: return OP_ANDI;
      CLS_LW:   return OP_LW;
      CLS_SW:   return OP_SW;
      CLS_BEQ:  return OP_BEQ;
      default:  return OP_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic operation class plus fields in, 32-bit MIPS word out.
// Class 7 yields a zero word and raises the illegal flag.
module instr_pack
  import mips_defs::*;
(
  input  logic [2:0]  opClass,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  opClass_e cls;
  assign cls = opClass_e'(opClass);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    word    = 32'h0;
    illegal = 1'b0;
    case (cls)
      CLS_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
      CLS_ADDI, CLS_ANDI, CLS_LW, CLS_SW, CLS_BEQ:
                 word = {iTypeOpcode(cls), rs, rt, imm};
      CLS_J:     word = {OP_J, target};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: accepts symbolic instructions and writes packed words sequentially
// into instruction memory. Define INSTR_ENCODER_CHECKSUM_EN to build the running XOR checksum.
module instr_encoder
  import mips_defs::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [5:0]        i_funct,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err,
  output logic [31:0]       o_checksum
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  loadState_e      state, stateNext;
  logic [ADDR_W:0] count;
  logic [31:0]     word;
  logic            illegal;
  logic            accept;
  logic            legalAccept;

  instr_pack u_pack (
    .opClass (i_op),
    .rs      (i_rs),
    .rt      (i_rt),
    .rd      (i_rd),
    .funct   (i_funct),
    .imm     (i_imm),
    .target  (i_target),
    .word    (word),
    .illegal (illegal)
  );

  assign o_ready     = (state == S_LOAD) && !i_clr;
  assign accept      = i_valid && o_ready;
  assign legalAccept = accept && !illegal;

  always_comb begin
    stateNext = state;
    if (i_clr) begin
      stateNext = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept && illegal)                   stateNext = S_ERR;
          else if (legalAccept && count == LAST_IDX) stateNext = S_FULL;
        end
        S_FULL:  stateNext = S_FULL;
        S_ERR:   stateNext = S_ERR;
        default: stateNext = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_LOAD;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= stateNext;
    end
  end

  // Write port and counter; i_clr forces the strobe low, and no beat is accepted while it is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'h0;
      count       <= '0;
      o_err       <= 1'b0;
    end else if (i_clr) begin
      o_mem_we <= 1'b0;
      count    <= '0;
      o_err    <= 1'b0;
    end else begin
      o_mem_we <= legalAccept;
      if (legalAccept) begin
        o_mem_addr  <= count[ADDR_W-1:0];
        o_mem_wdata <= word;
        count       <= count + 1'b1;
      end
      if (accept && illegal) o_err <= 1'b1;
    end
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] checksum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         checksum <= 32'h0;
    else if (i_clr)       checksum <= 32'h0;
    else if (legalAccept) checksum <= checksum ^ word;
  end

  assign o_checksum = checksum;
`else
  assign o_checksum = 32'h0;
`endif

  assign o_count = count;
  assign o_full  = (state == S_FULL);

endmodule
